// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: shared fetch/data memory port with wait states,
// internal register file, illegal-opcode halt and retired-instruction counter.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic             halted,
    output logic [31:0]      dbg_pc,
    output logic             dbg_wb_valid,
    output logic [4:0]       dbg_wb_reg,
    output logic [31:0]      dbg_wb_data,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0] pc, ir, a, b, alu_out, mdr, br_tgt;
    logic [XLEN-1:0] regs [NREG];

    logic [5:0]      op, funct;
    logic [4:0]      rs, rt, rd, shamt, wb_dst;
    logic [XLEN-1:0] sext_imm, alu_result, wb_value;
    logic            is_rtype, is_addi, is_lw, is_sw, is_beq, is_j;
    logic            funct_ok, insn_legal;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign sext_imm = {{16{ir[15]}}, ir[15:0]};

    assign is_rtype = (op == OP_RTYPE);
    assign is_addi  = (op == OP_ADDI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);

    assign funct_ok   = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_ADD) ||
                        (funct == FN_SUB) || (funct == FN_AND) || (funct == FN_OR)  ||
                        (funct == FN_SLT);
    assign insn_legal = (is_rtype && funct_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

    assign wb_dst   = is_rtype ? rd : rt;
    assign wb_value = is_lw ? mdr : alu_out;

    // ALU: R-type ops, otherwise base + sign-extended immediate (addi, lw, sw)
    always_comb begin
        alu_result = a + sext_imm;
        if (is_rtype) begin
            case (funct)
                FN_ADD:  alu_result = a + b;
                FN_SUB:  alu_result = a - b;
                FN_AND:  alu_result = a & b;
                FN_OR:   alu_result = a | b;
                FN_SLT:  alu_result = XLEN'($signed(a) < $signed(b));
                FN_SLL:  alu_result = b << shamt;
                FN_SRL:  alu_result = b >> shamt;
                default: alu_result = a + b;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = insn_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_lw || is_sw)           state_next = S_MEM;
                else if (is_rtype || is_addi) state_next = S_WB;
                else                          state_next = S_FETCH;
            end
            S_MEM:    if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Memory port is decoded straight from state so a request drops with rst at once
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {pc[31:2], 2'b00};
        mem_wdata = b;
        if (!rst) begin
            case (state)
                S_FETCH: mem_req = 1'b1;
                S_MEM: begin
                    mem_req  = 1'b1;
                    mem_we   = is_sw;
                    mem_addr = {alu_out[31:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

    // Datapath registers, register file, debug/retire outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            br_tgt       <= '0;
            halted       <= 1'b0;
            dbg_pc       <= RESET_PC;
            dbg_wb_valid <= 1'b0;
            dbg_wb_reg   <= '0;
            dbg_wb_data  <= '0;
            instret      <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            dbg_wb_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir     <= mem_rdata;
                        pc     <= pc + 32'd4;
                        dbg_pc <= pc;
                    end
                end
                S_DECODE: begin
                    a      <= regs[rs];
                    b      <= regs[rt];
                    br_tgt <= pc + {sext_imm[29:0], 2'b00};
                    if (!insn_legal) halted <= 1'b1;
                end
                S_EXEC: begin
                    alu_out <= alu_result;
                    if (is_rtype || is_addi) begin
                        dbg_wb_valid <= 1'b1;
                        dbg_wb_reg   <= wb_dst;
                        dbg_wb_data  <= alu_result;
                    end
                    if (is_beq) begin
                        if (a == b) pc <= br_tgt;
                        instret <= instret + CNT_W'(1);
                    end
                    if (is_j) begin
                        pc      <= {pc[31:28], ir[25:0], 2'b00};
                        instret <= instret + CNT_W'(1);
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_lw) begin
                            mdr          <= mem_rdata;
                            dbg_wb_valid <= 1'b1;
                            dbg_wb_reg   <= rt;
                            dbg_wb_data  <= mem_rdata;
                        end else begin
                            instret <= instret + CNT_W'(1);
                        end
                    end
                end
                S_WB: begin
                    // register 0 stays hard-wired to zero
                    if (wb_dst != 5'd0) regs[wb_dst] <= wb_value;
                    instret <= instret + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
